// File: rtl/prefetch_if.sv
// Fetch-bus and instruction-queue signals shared between the prefetcher,
// instruction memory and the decode stage.
interface prefetch_if;
   logic [31:0] fetch_addr;
   logic        fetch_request;
   logic        fetch_ready;
   logic        fetch_data_valid;
   logic [31:0] request_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   modport master (
      output fetch_addr, fetch_request, inst_valid, inst, inst_pc,
      input  fetch_ready, fetch_data_valid, request_data, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  fetch_addr, fetch_request, inst_valid, inst, inst_pc,
      output fetch_ready, fetch_data_valid, request_data, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/prefetch_unit.sv
// Sequential instruction prefetcher: credit-limited in-order fetch requests feeding
// a {pc,inst} queue, with redirect flush and squashing of in-flight responses.
module prefetch_unit #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] PC_START        = 32'h0000_2000,
   parameter logic [31:0] INSTR_NOP       = 32'h0000_0013
) (
   input logic       clk,
   input logic       reset,
   prefetch_if.master bus
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

   logic [31:0]   q_pc_r   [DEPTH];
   logic [31:0]   q_inst_r [DEPTH];
   logic [PW-1:0] head_r;
   logic [PW-1:0] tail_r;
   logic [CW-1:0] count_r;
   logic [OW-1:0] outstanding_r;
   logic [OW-1:0] squash_r;
   logic [31:0]   next_fetch_pc_r;
   logic [31:0]   resp_pc_r;

   logic          fetch_request_s;
   logic          accept_s;
   logic          resp_s;
   logic          drop_s;
   logic          push_s;
   logic          pop_s;
   logic [31:0]   redirect_base_s;
   logic [31:0]   inst_s;
   logic [31:0]   inst_pc_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
   endfunction

   // Credit and handshake decode; a redirect outranks push and pop in the same cycle.
   always_comb begin
      redirect_base_s = bus.redirect_pc & ~32'd3;
      fetch_request_s = !reset && !bus.redirect_valid
                        && (outstanding_r < OW'(MAX_OUTSTANDING))
                        && ((SW'(count_r) + SW'(outstanding_r)) < SW'(DEPTH));
      accept_s        = fetch_request_s && bus.fetch_ready;
      // A response with nothing outstanding is a protocol error and is ignored.
      resp_s          = bus.fetch_data_valid && (outstanding_r != {OW{1'b0}});
      drop_s          = resp_s && (squash_r != {OW{1'b0}});
      push_s          = resp_s && (squash_r == {OW{1'b0}}) && !bus.redirect_valid;
      pop_s           = (count_r != {CW{1'b0}}) && bus.inst_ready && !bus.redirect_valid;
   end

   // Pointers, occupancy, credit counters and the two pc trackers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_r          <= {PW{1'b0}};
         tail_r          <= {PW{1'b0}};
         count_r         <= {CW{1'b0}};
         outstanding_r   <= {OW{1'b0}};
         squash_r        <= {OW{1'b0}};
         next_fetch_pc_r <= PC_START;
         resp_pc_r       <= PC_START;
      end else if (bus.redirect_valid) begin
         head_r          <= {PW{1'b0}};
         tail_r          <= {PW{1'b0}};
         count_r         <= {CW{1'b0}};
         // Everything still in flight after this cycle belongs to the old stream.
         outstanding_r   <= outstanding_r - OW'(resp_s);
         squash_r        <= outstanding_r - OW'(resp_s);
         next_fetch_pc_r <= redirect_base_s;
         resp_pc_r       <= redirect_base_s;
      end else begin
         if (accept_s) begin
            next_fetch_pc_r <= next_fetch_pc_r + 32'd4;
         end else begin
            next_fetch_pc_r <= next_fetch_pc_r;
         end
         if (push_s) begin
            tail_r    <= ptr_inc(tail_r);
            resp_pc_r <= resp_pc_r + 32'd4;
         end else begin
            tail_r    <= tail_r;
            resp_pc_r <= resp_pc_r;
         end
         if (pop_s) begin
            head_r <= ptr_inc(head_r);
         end else begin
            head_r <= head_r;
         end
         count_r       <= count_r + CW'(push_s) - CW'(pop_s);
         outstanding_r <= outstanding_r + OW'(accept_s) - OW'(resp_s);
         squash_r      <= squash_r - OW'(drop_s);
      end
   end

   // Queue storage; entries are only read while counted as valid.
   always_ff @(posedge clk) begin
      if (push_s) begin
         q_pc_r[tail_r]   <= resp_pc_r;
         q_inst_r[tail_r] <= bus.request_data;
      end
   end

   // Head presentation; an empty queue shows a NOP at the pc expected next.
   always_comb begin
      inst_s    = INSTR_NOP;
      inst_pc_s = resp_pc_r;
      if (count_r != {CW{1'b0}}) begin
         inst_s    = q_inst_r[head_r];
         inst_pc_s = q_pc_r[head_r];
      end else begin
         inst_s    = INSTR_NOP;
         inst_pc_s = resp_pc_r;
      end
   end

   assign bus.fetch_addr    = next_fetch_pc_r;
   assign bus.fetch_request = fetch_request_s;
   assign bus.inst_valid    = (count_r != {CW{1'b0}});
   assign bus.inst          = inst_s;
   assign bus.inst_pc       = inst_pc_s;

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: a latency-programmable memory model answers fetches,
// a scoreboard monitor checks every popped {pc,inst} against the expected stream.
module tb_prefetch_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   prefetch_if bus();

   prefetch_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          mem_lat = 1;
   int          accepts = 0;
   int          pops = 0;
   logic [31:0] mem_addr_q [$];
   int          mem_due_q  [$];
   logic [31:0] exp_pc_q   [$];
   logic [31:0] exp_inst_q [$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC3C3_0000;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_stream(input logic [31:0] start);
      logic [31:0] a;
      exp_pc_q.delete();
      exp_inst_q.delete();
      a = start;
      for (int i = 0; i < 16; i++) begin
         exp_pc_q.push_back(a);
         exp_inst_q.push_back(mem_word(a));
         a = a + 32'd4;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Memory model: in-order responses mem_lat cycles after acceptance.
   initial begin
      bus.fetch_data_valid = 1'b0;
      bus.request_data     = 32'd0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mem_addr_q.delete();
            mem_due_q.delete();
         end else if (bus.fetch_request && bus.fetch_ready) begin
            mem_addr_q.push_back(bus.fetch_addr);
            mem_due_q.push_back(cyc + mem_lat);
            accepts++;
         end
         @(posedge clk);
         cyc++;
         #1;
         if (!reset && mem_addr_q.size() != 0 && mem_due_q[0] <= cyc) begin
            bus.fetch_data_valid = 1'b1;
            bus.request_data     = mem_word(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
         end else begin
            bus.fetch_data_valid = 1'b0;
            bus.request_data     = 32'd0;
         end
      end
   end

   // Scoreboard monitor: every accepted pop must match the head of the expected stream.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
            pops++;
            if (exp_pc_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: popped pc %h, expected nothing", bus.inst_pc);
            end else begin
               check32("sb_pc", bus.inst_pc, exp_pc_q.pop_front());
               check32("sb_inst", bus.inst, exp_inst_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int bubbles;
      int w;
      int p0;
      bus.fetch_ready    = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      bus.inst_ready     = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check32("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check32("rst_inst", bus.inst, 32'h0000_0013);
      check32("rst_inst_pc", bus.inst_pc, 32'h0000_2000);
      check32("rst_fetch_request", 32'(bus.fetch_request), 32'd0);
      check32("rst_fetch_addr", bus.fetch_addr, 32'h0000_2000);

      // Streaming with 1-cycle memory.
      expect_stream(32'h0000_2000);
      reset = 1'b0;
      #1;
      check32("t1_req_after_reset", 32'(bus.fetch_request), 32'd1);
      check32("t1_addr0", bus.fetch_addr, 32'h0000_2000);
      tick();
      check32("t1_addr1", bus.fetch_addr, 32'h0000_2004);
      check32("t1_valid_c1", 32'(bus.inst_valid), 32'd0);
      tick();
      check32("t1_addr2", bus.fetch_addr, 32'h0000_2008);
      check32("t1_valid_c2", 32'(bus.inst_valid), 32'd1);
      check32("t1_first_pc", bus.inst_pc, 32'h0000_2000);
      bubbles = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (!bus.inst_valid) bubbles++;
      end
      check32("t1_bubbles", bubbles, 32'd0);

      // Reset asserted between edges mid-stream.
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check32("t6_valid_drop", 32'(bus.inst_valid), 32'd0);
      check32("t6_req_drop", 32'(bus.fetch_request), 32'd0);
      bus.inst_ready = 1'b0;
      expect_stream(32'h0000_2000);
      repeat (2) tick();
      base = accepts;
      reset = 1'b0;
      #1;
      check32("t6_restart_addr", bus.fetch_addr, 32'h0000_2000);
      check32("t6_restart_req", 32'(bus.fetch_request), 32'd1);

      // Consumer stalled: queue fills to DEPTH and requests stop.
      repeat (8) tick();
      check32("t2_accepts", accepts - base, 32'd4);
      check32("t2_req_stopped", 32'(bus.fetch_request), 32'd0);
      check32("t2_valid", 32'(bus.inst_valid), 32'd1);
      check32("t2_head_pc", bus.inst_pc, 32'h0000_2000);
      check32("t2_head_inst", bus.inst, mem_word(32'h0000_2000));

      // Latency 3, redirect with two requests in flight.
      mem_lat = 3;
      bus.inst_ready = 1'b1;
      w = 0;
      while (!(mem_addr_q.size() == 2 && !bus.fetch_data_valid) && w < 20) begin
         tick();
         w++;
      end
      check32("t4_two_in_flight", mem_addr_q.size(), 32'd2);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_4001;
      expect_stream(32'h0000_4000);
      #1;
      check32("t4_no_req_in_redirect", 32'(bus.fetch_request), 32'd0);
      tick();
      bus.redirect_valid = 1'b0;
      check32("t4_flushed", 32'(bus.inst_valid), 32'd0);
      check32("t4_addr", bus.fetch_addr, 32'h0000_4000);
      w = 0;
      while (!bus.inst_valid && w < 20) begin
         tick();
         w++;
      end
      check32("t4_first_valid", 32'(bus.inst_valid), 32'd1);
      check32("t4_latency", w, 32'd5);
      check32("t4_first_pc", bus.inst_pc, 32'h0000_4000);
      check32("t4_first_inst", bus.inst, mem_word(32'h0000_4000));
      repeat (6) tick();

      // Redirect to the top of the address space; fetch pc and inst_pc wrap to zero.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFC;
      expect_stream(32'hFFFF_FFFC);
      tick();
      bus.redirect_valid = 1'b0;
      check32("t5_addr_top", bus.fetch_addr, 32'hFFFF_FFFC);
      w = 0;
      while (!bus.fetch_request && w < 10) begin
         tick();
         w++;
      end
      tick();
      check32("t5_addr_wrap", bus.fetch_addr, 32'h0000_0000);
      w = 0;
      while (!bus.inst_valid && w < 20) begin
         tick();
         w++;
      end
      check32("t5_first_pc", bus.inst_pc, 32'hFFFF_FFFC);
      p0 = pops;
      w = 0;
      while ((pops - p0) < 3 && w < 30) begin
         tick();
         w++;
      end
      check32("t5_wrapped_pops", 32'((pops - p0) >= 3), 32'd1);
      bus.inst_ready = 1'b0;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
